// File: rtl/mmu_port_arbiter_if.sv
// Bundle of the fetch, data, flush and MMU-side signals around mmu_port_arbiter.
// slave  : the arbiter's view (takes requests, drives the MMU port).
// master : the surrounding datapath/MMU view.
interface mmu_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [INST_W-1:0] if_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush_req;
  logic              stall;
  logic              mmu_valid;
  logic              mmu_we;
  logic [ADDR_W-1:0] mmu_addr;
  logic [DATA_W-1:0] mmu_wdata;
  logic [DATA_W-1:0] mmu_rdata;
  logic              mmu_ready;
  logic              mmu_flush;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush_req,
           mmu_rdata, mmu_ready,
    output if_ready, if_rdata, mem_ready, mem_rdata, stall,
           mmu_valid, mmu_we, mmu_addr, mmu_wdata, mmu_flush
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush_req,
           mmu_rdata, mmu_ready,
    input  if_ready, if_rdata, mem_ready, mem_rdata, stall,
           mmu_valid, mmu_we, mmu_addr, mmu_wdata, mmu_flush
  );
endinterface

// File: rtl/mmu_port_arbiter.sv
// Shares the single MMU port between instruction fetch and load/store, and
// sequences TLB flushes so they never overlap an in-flight access.
// Optional feature macro: RR_ARB_EN (round-robin arbitration; default is
// fixed priority with MEM beating IF).
module mmu_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned INST_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mmu_port_arbiter_if.slave bus
);
  localparam int unsigned   CNT_W      = 4;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  typedef enum logic [2:0] {IDLE, GNT_IF, GNT_MEM, RESP, FLUSH} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t           state, state_nxt;
  owner_t           last_owner, last_owner_nxt;
  logic             flush_pend, flush_pend_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pick_mem;
  logic             grant;
  logic             if_done;
  logic             mem_done;

  // Winner when at least one request is present in IDLE
  always_comb begin
`ifdef RR_ARB_EN
    pick_mem = bus.mem_req & ~(bus.if_req & (last_owner == OWN_MEM));
`else
    pick_mem = bus.mem_req;
`endif
  end

  // Next-state, grant and completion decode
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    flush_pend_nxt = flush_pend;
    cnt_nxt        = cnt;
    grant          = 1'b0;
    if_done        = 1'b0;
    mem_done       = 1'b0;
    case (state)
      IDLE: begin
        if (flush_pend || bus.flush_req) begin
          state_nxt = FLUSH;
          cnt_nxt   = FLUSH_LOAD;
        end else if (bus.mem_req || bus.if_req) begin
          grant          = 1'b1;
          state_nxt      = pick_mem ? GNT_MEM : GNT_IF;
          last_owner_nxt = pick_mem ? OWN_MEM : OWN_IF;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (bus.flush_req) flush_pend_nxt = 1'b1;
        if (bus.mmu_ready) begin
          if_done   = (state == GNT_IF);
          mem_done  = (state == GNT_MEM);
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.flush_req) flush_pend_nxt = 1'b1;
        state_nxt = IDLE;
      end
      FLUSH: begin
        if (bus.flush_req) begin
          cnt_nxt = FLUSH_LOAD;
        end else if (cnt <= CNT_W'(1)) begin
          state_nxt      = IDLE;
          flush_pend_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, owner, pending flush and flush counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OWN_IF;
      flush_pend <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      flush_pend <= flush_pend_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Registered MMU-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.mmu_valid <= 1'b0;
      bus.mmu_flush <= 1'b0;
      bus.mmu_we    <= 1'b0;
      bus.mmu_addr  <= '0;
      bus.mmu_wdata <= '0;
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mmu_valid <= (state_nxt == GNT_IF) || (state_nxt == GNT_MEM);
      bus.mmu_flush <= (state_nxt == FLUSH);
      bus.if_ready  <= if_done;
      bus.mem_ready <= mem_done;
      if (grant) begin
        bus.mmu_we    <= pick_mem & bus.mem_we;
        bus.mmu_addr  <= pick_mem ? bus.mem_addr : bus.if_addr;
        bus.mmu_wdata <= pick_mem ? bus.mem_wdata : '0;
      end
      if (if_done)  bus.if_rdata  <= bus.mmu_rdata[INST_W-1:0];
      if (mem_done) bus.mem_rdata <= bus.mmu_rdata;
    end
  end

  // Stall from live requests vs. registered readies; masked while in reset
  assign bus.stall = rst & ((bus.mem_req & ~bus.mem_ready) | (bus.if_req & ~bus.if_ready));

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Directed self-checking bench for mmu_port_arbiter (FLUSH_CYCLES = 2).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mmu_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mmu_port_arbiter_if bus ();

  mmu_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 64'h1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({bus.mmu_valid, bus.mmu_we, bus.mmu_flush, bus.if_ready, bus.mem_ready, bus.stall} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl c%0d: got %b want 000000", i, {bus.mmu_valid, bus.mmu_we, bus.mmu_flush, bus.if_ready, bus.mem_ready, bus.stall}); end
      n_cmp++; if ({bus.mmu_addr, bus.mmu_wdata, bus.mem_rdata, bus.if_rdata} !== '0) begin n_err++; $display("FAIL reset_data c%0d: got addr=%h wdata=%h mrd=%h ird=%h want 0", i, bus.mmu_addr, bus.mmu_wdata, bus.mem_rdata, bus.if_rdata); end
    end
    rst = 1'b1; bus.if_req = 1'b0;
  endtask

  task automatic test_if_fetch();
    tick(); bus.if_req = 1'b1; bus.if_addr = 64'h1000;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_we, bus.stall} !== 3'b101) begin n_err++; $display("FAIL fetch_grant: got valid/we/stall=%b want 101", {bus.mmu_valid, bus.mmu_we, bus.stall}); end
    n_cmp++; if (bus.mmu_addr !== 64'h1000) begin n_err++; $display("FAIL fetch_addr: got %h want 1000", bus.mmu_addr); end
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.if_ready} !== 2'b10) begin n_err++; $display("FAIL fetch_wait: got valid/ready=%b want 10", {bus.mmu_valid, bus.if_ready}); end
    tick(); bus.mmu_ready = 1'b1; bus.mmu_rdata = 64'hFFFF_FFFF_00A0_0093;
    tick(); bus.mmu_ready = 1'b0;
    n_cmp++; if ({bus.if_ready, bus.mem_ready, bus.mmu_valid, bus.stall} !== 4'b1000) begin n_err++; $display("FAIL fetch_ready: got if_rdy/mem_rdy/valid/stall=%b want 1000", {bus.if_ready, bus.mem_ready, bus.mmu_valid, bus.stall}); end
    n_cmp++; if (bus.if_rdata !== 32'h00A0_0093) begin n_err++; $display("FAIL fetch_rdata: got %h want 00a00093", bus.if_rdata); end
    bus.if_req = 1'b0;
    tick();
    n_cmp++; if ({bus.if_ready, bus.if_rdata} !== {1'b0, 32'h00A0_0093}) begin n_err++; $display("FAIL fetch_hold: got ready=%b rdata=%h want 0/00a00093", bus.if_ready, bus.if_rdata); end
  endtask

  task automatic test_arbitration();
    logic        first_mem;
    logic [63:0] r1;
    logic [63:0] r2;
    r1 = 64'h1111_2222_3333_4444;
    r2 = 64'h5555_6666_7777_8888;
`ifdef RR_ARB_EN
    first_mem = 1'b0;
`else
    first_mem = 1'b1;
`endif
    // MEM-only load first, so last_owner = MEM
    tick(); bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 64'h2008;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_we, bus.mmu_addr} !== {2'b10, 64'h2008}) begin n_err++; $display("FAIL load_grant: got valid=%b we=%b addr=%h want 1/0/2008", bus.mmu_valid, bus.mmu_we, bus.mmu_addr); end
    bus.mmu_ready = 1'b1; bus.mmu_rdata = 64'hCAFE_F00D_1234_5678;
    tick(); bus.mmu_ready = 1'b0;
    n_cmp++; if ({bus.mem_ready, bus.if_ready, bus.mem_rdata} !== {2'b10, 64'hCAFE_F00D_1234_5678}) begin n_err++; $display("FAIL load_ready: got mrdy=%b irdy=%b rdata=%h want 1/0/cafef00d12345678", bus.mem_ready, bus.if_ready, bus.mem_rdata); end
    n_cmp++; if (bus.if_rdata !== 32'h00A0_0093) begin n_err++; $display("FAIL if_rdata_hold: got %h want 00a00093", bus.if_rdata); end
    bus.mem_req = 1'b0;
    tick();
    // Both requesters present in the same IDLE cycle
    tick();
    bus.if_req = 1'b1; bus.if_addr = 64'h3000;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 64'h2000; bus.mem_wdata = 64'h55;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_we} !== {1'b1, first_mem}) begin n_err++; $display("FAIL arb1_we: got valid/we=%b want 1%b", {bus.mmu_valid, bus.mmu_we}, first_mem); end
    n_cmp++; if ({bus.mmu_addr, bus.mmu_wdata} !== (first_mem ? {64'h2000, 64'h55} : {64'h3000, 64'h0})) begin n_err++; $display("FAIL arb1_addr: got addr=%h wdata=%h first_mem=%b", bus.mmu_addr, bus.mmu_wdata, first_mem); end
    bus.mmu_ready = 1'b1; bus.mmu_rdata = r1;
    tick(); bus.mmu_ready = 1'b0;
    n_cmp++; if ({bus.if_ready, bus.mem_ready} !== (first_mem ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL arb1_ready: got if/mem=%b first_mem=%b", {bus.if_ready, bus.mem_ready}, first_mem); end
    if (first_mem) begin
      n_cmp++; if (bus.mem_rdata !== r1) begin n_err++; $display("FAIL arb1_mrdata: got %h want %h", bus.mem_rdata, r1); end
      bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    end else begin
      n_cmp++; if (bus.if_rdata !== r1[31:0]) begin n_err++; $display("FAIL arb1_irdata: got %h want %h", bus.if_rdata, r1[31:0]); end
      bus.if_req = 1'b0;
    end
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.if_ready, bus.mem_ready} !== 3'b000) begin n_err++; $display("FAIL arb_gap: got valid/irdy/mrdy=%b want 000", {bus.mmu_valid, bus.if_ready, bus.mem_ready}); end
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_we, bus.mmu_addr} !== (first_mem ? {2'b10, 64'h3000} : {2'b11, 64'h2000})) begin n_err++; $display("FAIL arb2_grant: got valid=%b we=%b addr=%h first_mem=%b", bus.mmu_valid, bus.mmu_we, bus.mmu_addr, first_mem); end
    bus.mmu_ready = 1'b1; bus.mmu_rdata = r2;
    tick(); bus.mmu_ready = 1'b0;
    if (first_mem) begin
      n_cmp++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, r2[31:0]}) begin n_err++; $display("FAIL arb2_ifdone: got rdy=%b rdata=%h want 1/%h", bus.if_ready, bus.if_rdata, r2[31:0]); end
    end else begin
      n_cmp++; if ({bus.mem_ready, bus.mem_rdata} !== {1'b1, r2}) begin n_err++; $display("FAIL arb2_memdone: got rdy=%b rdata=%h want 1/%h", bus.mem_ready, bus.mem_rdata, r2); end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    tick();
  endtask

  task automatic test_flush_during_access();
    tick(); bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 64'h4000; bus.mem_wdata = 64'hAA;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_flush} !== 2'b10) begin n_err++; $display("FAIL fl_grant: got valid/flush=%b want 10", {bus.mmu_valid, bus.mmu_flush}); end
    bus.flush_req = 1'b1; bus.if_req = 1'b1; bus.if_addr = 64'h5000;
    tick(); bus.flush_req = 1'b0;
    n_cmp++; if ({bus.mmu_valid, bus.mmu_flush, bus.mmu_addr} !== {2'b10, 64'h4000}) begin n_err++; $display("FAIL fl_inflight: got valid=%b flush=%b addr=%h want 1/0/4000", bus.mmu_valid, bus.mmu_flush, bus.mmu_addr); end
    bus.mmu_ready = 1'b1;
    tick(); bus.mmu_ready = 1'b0;
    n_cmp++; if ({bus.mem_ready, bus.if_ready, bus.mmu_flush} !== 3'b100) begin n_err++; $display("FAIL fl_memdone: got mrdy/irdy/flush=%b want 100", {bus.mem_ready, bus.if_ready, bus.mmu_flush}); end
    bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_flush} !== 2'b00) begin n_err++; $display("FAIL fl_idle: got valid/flush=%b want 00", {bus.mmu_valid, bus.mmu_flush}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if ({bus.mmu_flush, bus.mmu_valid, bus.stall} !== 3'b101) begin n_err++; $display("FAIL fl_strobe c%0d: got flush/valid/stall=%b want 101", i, {bus.mmu_flush, bus.mmu_valid, bus.stall}); end
    end
    tick();
    n_cmp++; if ({bus.mmu_flush, bus.mmu_valid} !== 2'b00) begin n_err++; $display("FAIL fl_end: got flush/valid=%b want 00", {bus.mmu_flush, bus.mmu_valid}); end
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_addr} !== {1'b1, 64'h5000}) begin n_err++; $display("FAIL fl_if_grant: got valid=%b addr=%h want 1/5000", bus.mmu_valid, bus.mmu_addr); end
    bus.mmu_ready = 1'b1; bus.mmu_rdata = 64'h0000_0000_0000_0013;
    tick(); bus.mmu_ready = 1'b0;
    n_cmp++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h13}) begin n_err++; $display("FAIL fl_if_done: got rdy=%b rdata=%h want 1/00000013", bus.if_ready, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_ignored_ready();
    tick(); bus.mmu_ready = 1'b1;
    tick();
    n_cmp++; if ({bus.if_ready, bus.mem_ready, bus.mmu_valid} !== 3'b000) begin n_err++; $display("FAIL idle_ready: got irdy/mrdy/valid=%b want 000", {bus.if_ready, bus.mem_ready, bus.mmu_valid}); end
    bus.flush_req = 1'b1;
    tick(); bus.flush_req = 1'b0;
    n_cmp++; if ({bus.mmu_flush, bus.if_ready, bus.mem_ready} !== 3'b100) begin n_err++; $display("FAIL flush_ready c0: got flush/irdy/mrdy=%b want 100", {bus.mmu_flush, bus.if_ready, bus.mem_ready}); end
    tick();
    // Re-flush on the last flush cycle restarts the count: two more cycles follow
    bus.flush_req = 1'b1;
    n_cmp++; if ({bus.mmu_flush, bus.if_ready, bus.mem_ready} !== 3'b100) begin n_err++; $display("FAIL flush_ready c1: got flush/irdy/mrdy=%b want 100", {bus.mmu_flush, bus.if_ready, bus.mem_ready}); end
    for (int i = 0; i < 2; i++) begin
      tick(); bus.flush_req = 1'b0;
      n_cmp++; if ({bus.mmu_flush, bus.if_ready, bus.mem_ready} !== 3'b100) begin n_err++; $display("FAIL flush_restart c%0d: got flush/irdy/mrdy=%b want 100", i, {bus.mmu_flush, bus.if_ready, bus.mem_ready}); end
    end
    tick(); bus.mmu_ready = 1'b0;
    n_cmp++; if ({bus.mmu_flush, bus.if_ready, bus.mem_ready} !== 3'b000) begin n_err++; $display("FAIL flush_exit: got flush/irdy/mrdy=%b want 000", {bus.mmu_flush, bus.if_ready, bus.mem_ready}); end
    // Address hold across a 5-cycle wait while if_addr wanders
    bus.if_req = 1'b1; bus.if_addr = 64'h6000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if ({bus.mmu_valid, bus.mmu_addr} !== {1'b1, 64'h6000}) begin n_err++; $display("FAIL addr_hold c%0d: got valid=%b addr=%h want 1/6000", i, bus.mmu_valid, bus.mmu_addr); end
      bus.if_addr = 64'h7000 + 64'(i * 8);
    end
    bus.mmu_ready = 1'b1; bus.mmu_rdata = 64'h0000_0000_ABCD_0001;
    tick(); bus.mmu_ready = 1'b0;
    n_cmp++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'hABCD_0001}) begin n_err++; $display("FAIL hold_done: got rdy=%b rdata=%h want 1/abcd0001", bus.if_ready, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    tick(); bus.if_req = 1'b1; bus.if_addr = 64'h8000;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_addr} !== {1'b1, 64'h8000}) begin n_err++; $display("FAIL rm_grant: got valid=%b addr=%h want 1/8000", bus.mmu_valid, bus.mmu_addr); end
    bus.flush_req = 1'b1;
    tick(); bus.flush_req = 1'b0; rst = 1'b0; bus.mmu_ready = 1'b1;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.if_ready, bus.mmu_flush, bus.stall} !== 4'b0000) begin n_err++; $display("FAIL rm_abort: got valid/irdy/flush/stall=%b want 0000", {bus.mmu_valid, bus.if_ready, bus.mmu_flush, bus.stall}); end
    rst = 1'b1; bus.if_req = 1'b0; bus.mmu_ready = 1'b0;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.if_ready, bus.mmu_flush} !== 3'b000) begin n_err++; $display("FAIL rm_idle: got valid/irdy/flush=%b want 000", {bus.mmu_valid, bus.if_ready, bus.mmu_flush}); end
    bus.if_req = 1'b1; bus.if_addr = 64'h9000;
    tick();
    n_cmp++; if ({bus.mmu_valid, bus.mmu_flush, bus.mmu_addr} !== {2'b10, 64'h9000}) begin n_err++; $display("FAIL rm_fresh: got valid=%b flush=%b addr=%h want 1/0/9000", bus.mmu_valid, bus.mmu_flush, bus.mmu_addr); end
    bus.mmu_ready = 1'b1; bus.mmu_rdata = 64'h0000_0000_0000_0067;
    tick(); bus.mmu_ready = 1'b0;
    n_cmp++; if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h67}) begin n_err++; $display("FAIL rm_done: got rdy=%b rdata=%h want 1/00000067", bus.if_ready, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.flush_req = 1'b0; bus.mmu_ready = 1'b0; bus.mmu_rdata = '0;
    test_reset();
    test_if_fetch();
    test_arbitration();
    test_flush_during_access();
    test_ignored_ready();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
